// File: rtl/qar_uart_pkg.sv
// Shared constants, FSM state types, per-frame config payloads and the parity
// helper used by the qar_uart485_ctrl block.
package qar_uart_pkg;

    localparam int unsigned OVERSAMPLE = 16;
    localparam int unsigned MID_SAMPLE = 8;
    localparam int unsigned TICK_W     = 4;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_LEAD,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP,
        TX_TAIL
    } tx_state_e;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_e;

    // Line options captured at TX accept.
    typedef struct packed {
        logic parity_en;
        logic stop2;
        logic echo;
    } tx_cfg_t;

    // Line options captured at the RX start edge.
    typedef struct packed {
        logic       parity_en;
        logic       parity_odd;
        logic [3:0] idle_bits;
    } rx_cfg_t;

    // Parity over the low 'width' bits; odd=1 makes the total count of ones odd.
    function automatic logic calc_parity(input logic [8:0] data,
                                         input int unsigned width,
                                         input logic odd);
        logic [8:0] mask;
        mask = 9'((32'd1 << width) - 32'd1);
        return odd ^ (^(data & mask));
    endfunction

endpackage

// File: rtl/qar_sync_fifo.sv
// Synchronous FIFO with occupancy output. Push while full is accepted only when
// a pop happens in the same cycle; pop while empty is ignored.
// Ports: clk, rst_n (sync, active-low), push/push_data, pop/pop_data (head),
//        level (occupancy), full, empty.
module qar_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             push_ok, pop_ok;

    // Pointer and occupancy update
    always_comb begin
        pop_ok   = pop && (count_q != '0);
        push_ok  = push && ((count_q != FULL_LVL) || pop_ok);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (push_ok && !pop_ok) begin
            count_d = count_q + (AW+1)'(1);
        end else if (!push_ok && pop_ok) begin
            count_d = count_q - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; occupancy gates visibility.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign pop_data = mem_q[rd_ptr_q];
    assign level    = count_q;
    assign full     = (count_q == FULL_LVL);
    assign empty    = (count_q == '0);

endmodule

// File: rtl/qar_uart485_ctrl.sv
// Half-duplex UART / RS-485 controller: oversampled tick generator, TX FSM with
// DE lead/tail guard bits, RX FSM with mid-bit sampling, RX FIFO, idle detector.
// Ports: clk, rst_n (sync, active-low); cfg_* static line config;
//        tx_valid/tx_ready/tx_data/tx_busy TX stream;
//        rx_valid/rx_ready/rx_data/rx_level RX stream and occupancy;
//        rx_overrun/rx_frame_err/rx_parity_err/rx_idle one-cycle event pulses;
//        uart_tx/uart_rx line, uart_de driver enable, uart_re receiver enable (low active).
module qar_uart485_ctrl
    import qar_uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned RX_FIFO_DEPTH = 4,
    parameter int unsigned CLK_DIV_WIDTH = 16,
    parameter int unsigned DE_LEAD_BITS  = 1,
    parameter int unsigned DE_TAIL_BITS  = 1
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [CLK_DIV_WIDTH-1:0]           cfg_div,
    input  logic                               cfg_parity_en,
    input  logic                               cfg_parity_odd,
    input  logic                               cfg_stop2,
    input  logic                               cfg_echo,
    input  logic [3:0]                         cfg_idle_bits,
    input  logic                               tx_valid,
    output logic                               tx_ready,
    input  logic [DATA_WIDTH-1:0]              tx_data,
    output logic                               tx_busy,
    output logic                               rx_valid,
    input  logic                               rx_ready,
    output logic [DATA_WIDTH-1:0]              rx_data,
    output logic [$clog2(RX_FIFO_DEPTH):0]     rx_level,
    output logic                               rx_overrun,
    output logic                               rx_frame_err,
    output logic                               rx_parity_err,
    output logic                               rx_idle,
    output logic                               uart_tx,
    input  logic                               uart_rx,
    output logic                               uart_de,
    output logic                               uart_re
);

    localparam int unsigned BIT_CNT_W  = 8;
    localparam int unsigned IDLE_CNT_W = 8;

    // ------------------------------------------------------------------
    // Oversample tick generator
    // ------------------------------------------------------------------
    logic [CLK_DIV_WIDTH-1:0] div_cnt_q, div_cnt_d;
    logic                     tick;

    always_comb begin
        tick      = (div_cnt_q == '0);
        div_cnt_d = tick ? cfg_div : div_cnt_q - CLK_DIV_WIDTH'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // TX FSM
    // ------------------------------------------------------------------
    tx_state_e             tx_state_q, tx_state_d;
    logic [TICK_W-1:0]     tx_tick_q, tx_tick_d;
    logic [BIT_CNT_W-1:0]  tx_bit_q, tx_bit_d;
    logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
    logic                  tx_par_q, tx_par_d;
    tx_cfg_t               tx_cfg_q, tx_cfg_d;
    logic                  uart_tx_q, uart_tx_d;
    logic                  uart_de_q, uart_de_d;
    logic                  uart_re_q, uart_re_d;
    logic                  tx_bit_end;

    always_comb begin
        tx_state_d = tx_state_q;
        tx_tick_d  = tx_tick_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_par_d   = tx_par_q;
        tx_cfg_d   = tx_cfg_q;
        uart_tx_d  = 1'b1;
        tx_bit_end = tick && (tx_tick_q == TICK_W'(OVERSAMPLE - 1));

        if (tick) begin
            tx_tick_d = tx_tick_q + TICK_W'(1);
        end

        case (tx_state_q)
            TX_IDLE: begin
                tx_tick_d = '0;
                tx_bit_d  = '0;
                if (tx_valid) begin
                    tx_shift_d = tx_data;
                    tx_par_d   = calc_parity(9'(tx_data), DATA_WIDTH, cfg_parity_odd);
                    tx_cfg_d   = '{parity_en: cfg_parity_en, stop2: cfg_stop2, echo: cfg_echo};
                    tx_state_d = (DE_LEAD_BITS != 0) ? TX_LEAD : TX_START;
                end
            end
            TX_LEAD: begin
                if (tx_bit_end) begin
                    if (tx_bit_q == BIT_CNT_W'(DE_LEAD_BITS - 1)) begin
                        tx_bit_d   = '0;
                        tx_state_d = TX_START;
                    end else begin
                        tx_bit_d = tx_bit_q + BIT_CNT_W'(1);
                    end
                end
            end
            TX_START: begin
                if (tx_bit_end) begin
                    tx_bit_d   = '0;
                    tx_state_d = TX_DATA;
                end
            end
            TX_DATA: begin
                if (tx_bit_end) begin
                    tx_shift_d = tx_shift_q >> 1;
                    if (tx_bit_q == BIT_CNT_W'(DATA_WIDTH - 1)) begin
                        tx_bit_d   = '0;
                        tx_state_d = tx_cfg_q.parity_en ? TX_PARITY : TX_STOP;
                    end else begin
                        tx_bit_d = tx_bit_q + BIT_CNT_W'(1);
                    end
                end
            end
            TX_PARITY: begin
                if (tx_bit_end) begin
                    tx_state_d = TX_STOP;
                end
            end
            TX_STOP: begin
                if (tx_bit_end) begin
                    if (tx_cfg_q.stop2 && (tx_bit_q == '0)) begin
                        tx_bit_d = BIT_CNT_W'(1);
                    end else begin
                        tx_bit_d   = '0;
                        tx_state_d = (DE_TAIL_BITS != 0) ? TX_TAIL : TX_IDLE;
                    end
                end
            end
            TX_TAIL: begin
                if (tx_bit_end) begin
                    if (tx_bit_q == BIT_CNT_W'(DE_TAIL_BITS - 1)) begin
                        tx_bit_d   = '0;
                        tx_state_d = TX_IDLE;
                    end else begin
                        tx_bit_d = tx_bit_q + BIT_CNT_W'(1);
                    end
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase

        // Line level registered from the state being entered
        case (tx_state_d)
            TX_START:  uart_tx_d = 1'b0;
            TX_DATA:   uart_tx_d = tx_shift_d[0];
            TX_PARITY: uart_tx_d = tx_par_d;
            default:   uart_tx_d = 1'b1;
        endcase

        uart_de_d = (tx_state_d != TX_IDLE);
        uart_re_d = uart_de_d & ~tx_cfg_d.echo;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_state_q <= TX_IDLE;
            tx_tick_q  <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_par_q   <= 1'b0;
            tx_cfg_q   <= '0;
            uart_tx_q  <= 1'b1;
            uart_de_q  <= 1'b0;
            uart_re_q  <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_tick_q  <= tx_tick_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_par_q   <= tx_par_d;
            tx_cfg_q   <= tx_cfg_d;
            uart_tx_q  <= uart_tx_d;
            uart_de_q  <= uart_de_d;
            uart_re_q  <= uart_re_d;
        end
    end

    assign tx_ready = (tx_state_q == TX_IDLE);
    assign tx_busy  = (tx_state_q != TX_IDLE);
    assign uart_tx  = uart_tx_q;
    assign uart_de  = uart_de_q;
    assign uart_re  = uart_re_q;

    // ------------------------------------------------------------------
    // RX path
    // ------------------------------------------------------------------
    logic                  rx_meta_q, rx_sync_q, rx_prev_q;
    rx_state_e             rx_state_q, rx_state_d;
    logic [TICK_W-1:0]     rx_tick_q, rx_tick_d;
    logic [BIT_CNT_W-1:0]  rx_bit_q, rx_bit_d;
    logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d;
    logic                  rx_par_bit_q, rx_par_bit_d;
    rx_cfg_t               rx_cfg_q, rx_cfg_d;
    logic                  idle_armed_q, idle_armed_d;
    logic [IDLE_CNT_W-1:0] idle_cnt_q, idle_cnt_d;
    logic [IDLE_CNT_W-1:0] idle_limit;
    logic                  rx_overrun_q, rx_overrun_d;
    logic                  rx_frame_err_q, rx_frame_err_d;
    logic                  rx_parity_err_q, rx_parity_err_d;
    logic                  rx_idle_q, rx_idle_d;
    logic                  rx_fall, rx_mid, rx_block, frame_done;
    logic                  fifo_push, fifo_pop, fifo_full, fifo_empty;

    // Receiver is blind while our own driver owns the bus without echo.
    assign rx_block = uart_re_q;
    assign fifo_pop = ~fifo_empty & rx_ready;

    always_comb begin
        rx_state_d      = rx_state_q;
        rx_tick_d       = rx_tick_q;
        rx_bit_d        = rx_bit_q;
        rx_shift_d      = rx_shift_q;
        rx_par_bit_d    = rx_par_bit_q;
        rx_cfg_d        = rx_cfg_q;
        idle_armed_d    = idle_armed_q;
        idle_cnt_d      = idle_cnt_q;
        rx_overrun_d    = 1'b0;
        rx_frame_err_d  = 1'b0;
        rx_parity_err_d = 1'b0;
        rx_idle_d       = 1'b0;
        fifo_push       = 1'b0;
        frame_done      = 1'b0;
        rx_fall         = rx_prev_q & ~rx_sync_q;
        rx_mid          = tick && (rx_tick_q == TICK_W'(OVERSAMPLE - 1));
        idle_limit      = IDLE_CNT_W'(rx_cfg_q.idle_bits) * IDLE_CNT_W'(OVERSAMPLE);

        if (tick) begin
            rx_tick_d = rx_tick_q + TICK_W'(1);
        end

        case (rx_state_q)
            RX_IDLE: begin
                rx_tick_d = '0;
                rx_bit_d  = '0;
                if (rx_fall && !rx_block) begin
                    rx_state_d = RX_START;
                    rx_cfg_d   = '{parity_en: cfg_parity_en, parity_odd: cfg_parity_odd,
                                   idle_bits: cfg_idle_bits};
                    idle_cnt_d = '0;
                end
            end
            RX_START: begin
                // Mid start bit: a high line means the edge was a glitch.
                if (tick && (rx_tick_q == TICK_W'(MID_SAMPLE - 1))) begin
                    if (rx_sync_q) begin
                        rx_state_d = RX_IDLE;
                    end else begin
                        rx_tick_d  = '0;
                        rx_bit_d   = '0;
                        rx_state_d = RX_DATA;
                    end
                end
            end
            RX_DATA: begin
                if (rx_mid) begin
                    rx_shift_d = {rx_sync_q, rx_shift_q[DATA_WIDTH-1:1]};
                    if (rx_bit_q == BIT_CNT_W'(DATA_WIDTH - 1)) begin
                        rx_bit_d   = '0;
                        rx_state_d = rx_cfg_q.parity_en ? RX_PARITY : RX_STOP;
                    end else begin
                        rx_bit_d = rx_bit_q + BIT_CNT_W'(1);
                    end
                end
            end
            RX_PARITY: begin
                if (rx_mid) begin
                    rx_par_bit_d = rx_sync_q;
                    rx_state_d   = RX_STOP;
                end
            end
            RX_STOP: begin
                if (rx_mid) begin
                    rx_state_d = RX_IDLE;
                    frame_done = 1'b1;
                    if (!rx_sync_q) begin
                        rx_frame_err_d = 1'b1;
                    end else if (rx_cfg_q.parity_en &&
                                 (rx_par_bit_q != calc_parity(9'(rx_shift_q), DATA_WIDTH,
                                                              rx_cfg_q.parity_odd))) begin
                        rx_parity_err_d = 1'b1;
                    end else if (fifo_full && !fifo_pop) begin
                        rx_overrun_d = 1'b1;
                    end else begin
                        fifo_push = 1'b1;
                    end
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase

        if (rx_block) begin
            rx_state_d = RX_IDLE;
        end

        // Idle detector: armed by any finished frame, fires once per arming.
        if (frame_done) begin
            idle_armed_d = 1'b1;
            idle_cnt_d   = '0;
        end else if (idle_armed_q && tick && rx_sync_q && (rx_state_q == RX_IDLE) &&
                     (rx_cfg_q.idle_bits != '0)) begin
            idle_cnt_d = idle_cnt_q + IDLE_CNT_W'(1);
            if (idle_cnt_d == idle_limit) begin
                rx_idle_d    = 1'b1;
                idle_armed_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_meta_q       <= 1'b1;
            rx_sync_q       <= 1'b1;
            rx_prev_q       <= 1'b1;
            rx_state_q      <= RX_IDLE;
            rx_tick_q       <= '0;
            rx_bit_q        <= '0;
            rx_shift_q      <= '0;
            rx_par_bit_q    <= 1'b0;
            rx_cfg_q        <= '0;
            idle_armed_q    <= 1'b0;
            idle_cnt_q      <= '0;
            rx_overrun_q    <= 1'b0;
            rx_frame_err_q  <= 1'b0;
            rx_parity_err_q <= 1'b0;
            rx_idle_q       <= 1'b0;
        end else begin
            rx_meta_q       <= uart_rx;
            rx_sync_q       <= rx_meta_q;
            rx_prev_q       <= rx_sync_q;
            rx_state_q      <= rx_state_d;
            rx_tick_q       <= rx_tick_d;
            rx_bit_q        <= rx_bit_d;
            rx_shift_q      <= rx_shift_d;
            rx_par_bit_q    <= rx_par_bit_d;
            rx_cfg_q        <= rx_cfg_d;
            idle_armed_q    <= idle_armed_d;
            idle_cnt_q      <= idle_cnt_d;
            rx_overrun_q    <= rx_overrun_d;
            rx_frame_err_q  <= rx_frame_err_d;
            rx_parity_err_q <= rx_parity_err_d;
            rx_idle_q       <= rx_idle_d;
        end
    end

    assign rx_overrun    = rx_overrun_q;
    assign rx_frame_err  = rx_frame_err_q;
    assign rx_parity_err = rx_parity_err_q;
    assign rx_idle       = rx_idle_q;
    assign rx_valid      = ~fifo_empty;

    qar_sync_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (RX_FIFO_DEPTH)
    ) u_rx_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .push_data (rx_shift_q),
        .pop       (fifo_pop),
        .pop_data  (rx_data),
        .level     (rx_level),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule
